// File: rtl/ft_ctrl_pkg.sv
// rtl/ft_ctrl_pkg.sv - shared types and constants for the FT telemetry command controller
package ft_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_STATUS = 8'h01;
  localparam logic [7:0] OP_CLEAR  = 8'h02;
  localparam logic [7:0] NAK_TAG   = 8'hEE;

  localparam logic [2:0] LEN_STATUS = 3'd6;
  localparam logic [2:0] LEN_ACK    = 3'd2;

  function automatic logic [2:0] rsp_len(input logic [7:0] op);
    return (op == OP_STATUS) ? LEN_STATUS : LEN_ACK;
  endfunction

endpackage

// File: rtl/ft_telem_ctrl.sv
// rtl/ft_telem_ctrl.sv - FT FIFO command decoder and fixed-length response framer
module ft_telem_ctrl
  import ft_ctrl_pkg::*;
#(
  parameter logic [7:0]  CMD_HDR = 8'hA5,
  parameter logic [15:0] RSP_HDR = 16'h5AA5
) (
  input  logic        clk_128M,
  input  logic        rst_128M,
  input  logic [15:0] ui_dout,
  input  logic        ui_dout_empty,
  output logic        ui_dout_get,
  output logic [15:0] ui_din,
  output logic [1:0]  ui_din_be,
  output logic        ui_din_valid,
  input  logic        ui_din_full,
  input  logic [31:0] total_packets,
  input  logic [31:0] mismatch_packets,
  input  logic        okay_led,
  input  logic        link_count_okay,
  output logic        reset_counters,
  output logic        busy
);

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_op;
  logic [7:0]  r_drop_cnt;
  logic [31:0] r_total;
  logic [31:0] r_mismatch;
  logic [15:0] r_flags;
  logic [2:0]  r_idx;
  logic [15:0] r_din;
  logic        r_din_valid;
  logic        r_reset_counters;

  logic        w_pop;
  logic        w_is_cmd;
  logic        w_last;
  logic [2:0]  w_idx_sel;
  logic [15:0] w_word_sel;

  assign w_pop    = ui_dout_get && !ui_dout_empty;
  assign w_is_cmd = (ui_dout[15:8] == CMD_HDR);
  assign w_last   = (r_idx == rsp_len(r_op) - 3'd1);

  // EXEC preloads word 0; in SEND the register is loaded with the word after the one being accepted.
  assign w_idx_sel = (r_state == ST_EXEC) ? 3'd0 : r_idx + 3'd1;

  always_comb begin
    w_word_sel = 16'h0000;
    case (w_idx_sel)
      3'd0: w_word_sel = RSP_HDR;
      3'd1: begin
        if (r_op == OP_STATUS)     w_word_sel = r_total[31:16];
        else if (r_op == OP_CLEAR) w_word_sel = 16'h0002;
        else                       w_word_sel = {NAK_TAG, r_op};
      end
      3'd2: w_word_sel = r_total[15:0];
      3'd3: w_word_sel = r_mismatch[31:16];
      3'd4: w_word_sel = r_mismatch[15:0];
      3'd5: w_word_sel = r_flags;
      default: w_word_sel = 16'h0000;
    endcase
  end

  always_ff @(posedge clk_128M or posedge rst_128M) begin
    if (rst_128M) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_pop && w_is_cmd) w_next_state = ST_EXEC;
      ST_EXEC: w_next_state = (r_op == OP_NOP) ? ST_IDLE : ST_SEND;
      ST_SEND: if (!ui_din_full && w_last) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    ui_dout_get = (r_state == ST_IDLE) && !ui_dout_empty;
    busy        = (r_state != ST_IDLE);
  end

  always_ff @(posedge clk_128M or posedge rst_128M) begin
    if (rst_128M) begin
      r_op             <= 8'h00;
      r_drop_cnt       <= 8'h00;
      r_total          <= 32'h0;
      r_mismatch       <= 32'h0;
      r_flags          <= 16'h0;
      r_idx            <= 3'd0;
      r_din            <= 16'h0;
      r_din_valid      <= 1'b0;
      r_reset_counters <= 1'b0;
    end else begin
      r_reset_counters <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            if (w_is_cmd)                r_op <= ui_dout[7:0];
            else if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
          end
        end
        ST_EXEC: begin
          if (r_op == OP_STATUS) begin
            r_total    <= total_packets;
            r_mismatch <= mismatch_packets;
            r_flags    <= {r_drop_cnt, 6'b0, link_count_okay, okay_led};
          end
          if (r_op == OP_CLEAR) begin
            r_reset_counters <= 1'b1;
            r_drop_cnt       <= 8'h00;
          end
          if (r_op != OP_NOP) begin
            r_idx       <= 3'd0;
            r_din       <= w_word_sel;
            r_din_valid <= 1'b1;
          end
        end
        ST_SEND: begin
          if (!ui_din_full) begin
            if (w_last) begin
              r_idx       <= 3'd0;
              r_din       <= 16'h0;
              r_din_valid <= 1'b0;
            end else begin
              r_idx <= r_idx + 3'd1;
              r_din <= w_word_sel;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ui_din         = r_din;
  assign ui_din_valid   = r_din_valid;
  assign ui_din_be      = 2'b11;
  assign reset_counters = r_reset_counters;

endmodule

// File: tb/tb_ft_telem_ctrl.sv
// tb/tb_ft_telem_ctrl.sv - self-checking bench for ft_telem_ctrl against a frame-level model
module tb_ft_telem_ctrl;

  logic        clk_128M = 1'b0;
  logic        rst_128M;
  logic [15:0] ui_dout;
  logic        ui_dout_empty;
  logic        ui_dout_get;
  logic [15:0] ui_din;
  logic [1:0]  ui_din_be;
  logic        ui_din_valid;
  logic        ui_din_full;
  logic [31:0] total_packets;
  logic [31:0] mismatch_packets;
  logic        okay_led;
  logic        link_count_okay;
  logic        reset_counters;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int m_drop = 0;
  logic [15:0] exp_q[$];

  always #5 clk_128M = ~clk_128M;

  ft_telem_ctrl dut (
    .clk_128M         (clk_128M),
    .rst_128M         (rst_128M),
    .ui_dout          (ui_dout),
    .ui_dout_empty    (ui_dout_empty),
    .ui_dout_get      (ui_dout_get),
    .ui_din           (ui_din),
    .ui_din_be        (ui_din_be),
    .ui_din_valid     (ui_din_valid),
    .ui_din_full      (ui_din_full),
    .total_packets    (total_packets),
    .mismatch_packets (mismatch_packets),
    .okay_led         (okay_led),
    .link_count_okay  (link_count_okay),
    .reset_counters   (reset_counters),
    .busy             (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_frame(input logic [7:0] op);
    logic [7:0] d;
    d = m_drop[7:0];
    exp_q = {};
    if (op != 8'h00) begin
      exp_q.push_back(16'h5AA5);
      if (op == 8'h01) begin
        exp_q.push_back(total_packets[31:16]);
        exp_q.push_back(total_packets[15:0]);
        exp_q.push_back(mismatch_packets[31:16]);
        exp_q.push_back(mismatch_packets[15:0]);
        exp_q.push_back({d, 6'b0, link_count_okay, okay_led});
      end else if (op == 8'h02) begin
        exp_q.push_back(16'h0002);
      end else begin
        exp_q.push_back({8'hEE, op});
      end
    end
  endtask

  task automatic do_cmd(input logic [15:0] word, input bit rnd_full, input int stall_k,
                        input int stall_len, input bit mid_change);
    bit         is_cmd;
    logic [7:0] op;
    int         k;
    int         cyc;
    int         stall_left;
    bit         done;
    is_cmd = (word[15:8] == 8'hA5);
    op     = word[7:0];
    @(negedge clk_128M);
    ui_dout = word; ui_dout_empty = 1'b0; ui_din_full = 1'b0;
    #1;
    check("pop_get", ui_dout_get, 1);
    check("idle_busy", busy, 0);
    if (!is_cmd && m_drop < 255) m_drop++;
    @(negedge clk_128M);
    ui_dout_empty = 1'b1;
    #1;
    if (!is_cmd) begin
      check("junk_busy", busy, 0);
      return;
    end
    build_frame(op);
    if (op == 8'h02) m_drop = 0;
    check("exec_busy", busy, 1);
    check("exec_valid", ui_din_valid, 0);
    check("exec_get", ui_dout_get, 0);
    check("exec_rc", reset_counters, 0);
    k = 0; cyc = 2; stall_left = stall_len; done = 0;
    while (!done) begin
      @(negedge clk_128M);
      if (k == exp_q.size()) begin
        ui_dout_empty = 1'b1; ui_din_full = 1'b0;
        #1;
        check("end_valid", ui_din_valid, 0);
        check("end_busy", busy, 0);
        check("end_rc", reset_counters, 0);
        done = 1;
      end else begin
        ui_dout = 16'hA501;
        ui_dout_empty = 1'($urandom_range(0, 1));
        if (k == stall_k && stall_left > 0) begin
          ui_din_full = 1'b1; stall_left--;
        end else begin
          ui_din_full = rnd_full ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        if (mid_change) begin
          total_packets = $urandom; mismatch_packets = $urandom;
          okay_led = 1'($urandom_range(0, 1)); link_count_okay = 1'($urandom_range(0, 1));
        end
        #1;
        check("send_busy", busy, 1);
        check("send_get", ui_dout_get, 0);
        check("send_valid", ui_din_valid, 1);
        check("send_be", ui_din_be, 2'b11);
        check($sformatf("send_word%0d", k), ui_din, exp_q[k]);
        check("send_rc", reset_counters, (op == 8'h02 && cyc == 2));
        if (!ui_din_full) k++;
        cyc++;
        if (cyc > 100) begin
          check("frame_timeout", k, exp_q.size());
          done = 1;
        end
      end
    end
  endtask

  initial begin
    logic [7:0] hdr;
    int         r;
    rst_128M = 1'b1; ui_dout = 16'h0; ui_dout_empty = 1'b1; ui_din_full = 1'b0;
    total_packets = 32'h12345678; mismatch_packets = 32'h0000_0003;
    okay_led = 1'b1; link_count_okay = 1'b0;
    repeat (2) @(negedge clk_128M);
    #1;
    check("rst_get", ui_dout_get, 0);
    check("rst_valid", ui_din_valid, 0);
    check("rst_din", ui_din, 0);
    check("rst_rc", reset_counters, 0);
    check("rst_busy", busy, 0);
    @(negedge clk_128M);
    rst_128M = 1'b0;

    do_cmd(16'hA501, 0, -1, 0, 0);

    repeat (3) do_cmd(16'h0001, 0, -1, 0, 0);
    do_cmd(16'hA502, 0, -1, 0, 0);
    do_cmd(16'hA501, 0, -1, 0, 0);

    do_cmd(16'hA57F, 0, -1, 0, 0);
    do_cmd(16'hA500, 0, -1, 0, 0);

    total_packets = 32'hCAFE_0001; mismatch_packets = 32'h0000_0042;
    do_cmd(16'hA501, 0, 2, 10, 1);

    for (int i = 0; i < 300; i++) begin
      @(negedge clk_128M);
      hdr = 8'($urandom_range(0, 255));
      if (hdr == 8'hA5) hdr = 8'h00;
      ui_dout = {hdr, 8'($urandom_range(0, 255))}; ui_dout_empty = 1'b0;
      #1;
      check("sat_get", ui_dout_get, 1);
      if (m_drop < 255) m_drop++;
    end
    do_cmd(16'hA501, 0, -1, 0, 0);

    @(negedge clk_128M);
    ui_dout = 16'hA501; ui_dout_empty = 1'b0;
    @(negedge clk_128M);
    ui_dout_empty = 1'b1;
    repeat (4) @(negedge clk_128M);
    #1;
    check("pre_rst_word3", ui_din, mismatch_packets[31:16]);
    rst_128M = 1'b1;
    #1;
    check("midrst_valid", ui_din_valid, 0);
    check("midrst_din", ui_din, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rc", reset_counters, 0);
    check("midrst_get", ui_dout_get, 0);
    @(negedge clk_128M);
    rst_128M = 1'b0;
    m_drop = 0;
    do_cmd(16'hA501, 0, -1, 0, 0);

    for (int i = 0; i < 40; i++) begin
      total_packets = $urandom; mismatch_packets = $urandom;
      okay_led = 1'($urandom_range(0, 1)); link_count_okay = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 4);
      case (r)
        0: begin
          hdr = 8'($urandom_range(0, 255));
          if (hdr == 8'hA5) hdr = 8'h5A;
          do_cmd({hdr, 8'($urandom_range(0, 255))}, 1, -1, 0, 1);
        end
        1: do_cmd(16'hA500, 1, -1, 0, 1);
        2: do_cmd(16'hA501, 1, -1, 0, 1);
        3: do_cmd(16'hA502, 1, -1, 0, 1);
        default: do_cmd({8'hA5, 8'($urandom_range(0, 255))}, 1, -1, 0, 1);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
